t_ff_mod_counter: RTL and testbench



---
 rtl/seq_pkg.sv | 17 +
 rtl/t_ff_cell.sv | 15 +
 rtl/t_ff_mod_counter.sv | 64 ++++++
 tb/tb_t_ff_mod_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants and helpers for the T-flip-flop sequential library
package seq_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int TOGGLE_MAX_WIDTH = 32;

    // Bits that must flip to move a T-cell register from cur to nxt; callers narrow the result.
    function automatic logic [TOGGLE_MAX_WIDTH-1:0] toggle_vec(
        input logic [TOGGLE_MAX_WIDTH-1:0] cur,
        input logic [TOGGLE_MAX_WIDTH-1:0] nxt
    );
        return cur ^ nxt;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: edge-triggered T flip-flop with synchronous active-low reset
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Clear on reset, otherwise flip when t is set.
    always_ff @(posedge clk) begin
        if (!rst) q <= 1'b0;
        else      q <= q ^ t;
    end

endmodule

// File: rtl/t_ff_mod_counter.sv
// t_ff_mod_counter: modulo-N up/down counter built from T flip-flop cells, cascadable via carry_out
module t_ff_mod_counter
    import seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || WIDTH > TOGGLE_MAX_WIDTH || MODULUS < 2 ||
            longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
            $error("t_ff_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    // Terminal value fits WIDTH bits; MODULUS itself is widened by one bit so 2**WIDTH survives.
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] t;
    logic             at_top;
    logic             at_bot;
    logic             in_range;

    // Next count from load/enable/direction, then the per-bit toggle vector toward it.
    always_comb begin
        at_top    = (q == TOP);
        at_bot    = (q == '0);
        in_range  = ({1'b0, load_val} < MOD_EXT);
        nxt       = load ? (in_range ? load_val : TOP) :
                    en   ? ((up == DIR_UP) ? (at_top ? '0 : q + 1'b1) :
                                             (at_bot ? TOP : q - 1'b1)) :
                           q;
        t         = WIDTH'(toggle_vec(TOGGLE_MAX_WIDTH'(q), TOGGLE_MAX_WIDTH'(nxt)));
        carry_out = rst & en & ~load & ((up == DIR_UP) ? at_top : at_bot);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    // Flag a clamped load for exactly the cycle after it; any other edge clears it.
    always_ff @(posedge clk) begin
        if (!rst) load_err <= 1'b0;
        else      load_err <= load & ~in_range;
    end

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// tb_t_ff_mod_counter: scoreboard bench driving a modulo-10 and a modulo-16 counter in parallel
module tb_t_ff_mod_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q10, q16;
    logic         c10, c16, e10, e16;

    t_ff_mod_counter #(.WIDTH(W), .MODULUS(10)) dut10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q10), .carry_out(c10), .load_err(e10)
    );

    t_ff_mod_counter #(.WIDTH(W), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q16), .carry_out(c16), .load_err(e16)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q10;
        logic       e10;
        logic       c10;
        logic [3:0] q16;
        logic       e16;
        logic       c16;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   mq[2] = '{0, 0};
    int   merr[2] = '{0, 0};
    int   mods[2] = '{10, 16};

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every falling edge with an outstanding expectation compares the DUT outputs.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                check("q_mod10", int'(q10), int'(r.q10));
                check("load_err_mod10", int'(e10), int'(r.e10));
                check("carry_mod10", int'(c10), int'(r.c10));
                check("q_mod16", int'(q16), int'(r.q16));
                check("load_err_mod16", int'(e16), int'(r.e16));
                check("carry_mod16", int'(c16), int'(r.c16));
            end
        end
    end

    // Drive one cycle of inputs, record what the outputs must show this cycle, advance the model.
    task automatic step(input bit r, input bit l, input bit e, input bit u, input int lv);
        exp_t x;
        int   c[2];
        @(posedge clk);
        #1;
        rst = r; load = l; en = e; up = u; load_val = W'(lv);
        for (int i = 0; i < 2; i++) begin
            int m = mods[i];
            c[i] = (r && e && !l && (u ? (mq[i] == m - 1) : (mq[i] == 0))) ? 1 : 0;
        end
        x.q10 = 4'(mq[0]); x.e10 = merr[0][0]; x.c10 = c[0][0];
        x.q16 = 4'(mq[1]); x.e16 = merr[1][0]; x.c16 = c[1][0];
        sb.push_back(x);
        for (int i = 0; i < 2; i++) begin
            int m = mods[i];
            if (!r) begin
                mq[i] = 0; merr[i] = 0;
            end else if (l) begin
                if (lv < m) begin mq[i] = lv;    merr[i] = 0; end
                else        begin mq[i] = m - 1; merr[i] = 1; end
            end else begin
                merr[i] = 0;
                if (e) mq[i] = u ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 1, 5);
        repeat (12) step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 3);
        step(1, 1, 1, 1, 7);
        repeat (2) step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 12);
        repeat (2) step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 5);
        step(0, 1, 1, 1, 5);
        repeat (3) step(1, 0, 1, 1, 0);
        step(1, 1, 0, 1, 14);
        repeat (3) step(1, 0, 1, 1, 0);
        step(1, 1, 0, 1, 15);
        repeat (2) step(1, 0, 1, 0, 0);
        for (int k = 0; k < 300; k++)
            step(($urandom % 16) != 0, ($urandom % 5) == 0, ($urandom % 4) != 0,
                 $urandom % 2, int'($urandom_range(0, 15)));
        step(1, 0, 0, 1, 0);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
